bcd_counter_display: RTL

Parametrised up/down event counter with N-digit multiplexed 7-segment output, the next generation of the board's button-driven BCD counter display. Two raw push-buttons are synchronised and debounced, the binary count is converted to BCD by a sequential double-dabble engine, and the digits are time-multiplexed onto one shared active-low segment bus. It sits between the board keys and the seven-segment connector; the binary count is also exported for other logic.

---
 rtl/disp_pkg.sv | 30 +++
 rtl/bin2bcd_seq.sv | 68 ++++++
 rtl/bcd_counter_display.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, engine state type and 7-segment decode for the BCD counter display.
// Contents:
//   SEG_BLANK      all segments off (active-low bus)
//   SEG_DASH       only segment g lit, shown for non-decimal nibbles
//   engine_state_t states of the sequential binary-to-BCD engine
//   seg_decode     BCD nibble -> active-low segment pattern, seg[0]=a ... seg[6]=g
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} engine_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one add-3-then-shift step per cycle.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load bin and begin a conversion (honoured in IDLE only)
//   bin         binary input, sampled on the start cycle
//   busy        high while SHIFT or DONE
//   done        high for the single DONE cycle; bcd is valid during it
//   bcd         BCD field of the shift register, digit 0 (most significant) in the top nibble
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int W        = 8,
    parameter int N_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd
);

    localparam int BW = 4 * N_DIGITS;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(W - 1);

    engine_state_t    state_q;
    logic [CW-1:0]    step_q;
    logic [BW+W-1:0]  sr_q;
    logic [BW+W-1:0]  shift_d;

    // BCD field sits above the binary field; nibbles >= 5 get +3 before the shift
    always_comb begin
        shift_d = sr_q;
        for (int i = 0; i < N_DIGITS; i++)
            shift_d[W+4*i +: 4] = sr_q[W+4*i +: 4] >= 4'd5 ? sr_q[W+4*i +: 4] + 4'd3 : sr_q[W+4*i +: 4];
        shift_d = shift_d << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            sr_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    sr_q    <= {{BW{1'b0}}, bin};
                    step_q  <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    sr_q    <= shift_d;
                    step_q  <= step_q + 1'b1;
                    state_q <= step_q == STEP_LAST ? DONE : SHIFT;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign bcd  = sr_q[W +: BW];

endmodule

// File: rtl/bcd_counter_display.sv
// bcd_counter_display: debounced up/down BCD counter driving a multiplexed active-low 7-segment display.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   key_inc, key_dec  raw active-low push-buttons (asynchronous)
//   blank_lz          1 = blank leading zeros
//   count             binary count, wraps between 0 and MAX_COUNT
//   seg               active-low segments, seg[0]=a ... seg[6]=g
//   an                active-low digit enables, digit 0 on an[AN_W-1], unused bits held 1
module bcd_counter_display
    import disp_pkg::*;
#(
    parameter int N_DIGITS     = 3,
    parameter int W            = 8,
    parameter int MAX_COUNT    = 255,
    parameter int DEBOUNCE_CYC = 50000,
    parameter int SCAN_CYC     = 50000,
    parameter int AN_W         = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_inc,
    input  logic            key_dec,
    input  logic            blank_lz,
    output logic [W-1:0]    count,
    output logic [6:0]      seg,
    output logic [AN_W-1:0] an
);

    localparam int BW = 4 * N_DIGITS;
    localparam int DW = $clog2(DEBOUNCE_CYC);
    localparam int SW = $clog2(SCAN_CYC);
    localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [SW-1:0] SC_LAST = SW'(SCAN_CYC - 1);
    localparam logic [IW-1:0] ID_LAST = IW'(N_DIGITS - 1);
    localparam logic [W-1:0]  MAX_V   = W'(MAX_COUNT);

    logic [1:0] key_raw;
    logic [1:0] press;

    assign key_raw = {key_dec, key_inc};

    // press[0] = increment, press[1] = decrement
    for (genvar k = 0; k < 2; k++) begin : g_db
        logic          s1_q, s2_q, lvl_q, lvl_prev_q, press_q;
        logic [DW-1:0] cnt_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_q       <= 1'b1;
                s2_q       <= 1'b1;
                lvl_q      <= 1'b1;
                lvl_prev_q <= 1'b1;
                press_q    <= 1'b0;
                cnt_q      <= '0;
            end else begin
                s1_q       <= key_raw[k];
                s2_q       <= s1_q;
                lvl_prev_q <= lvl_q;
                press_q    <= lvl_prev_q & ~lvl_q;
                if (s2_q == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_q <= '0;
                    lvl_q <= s2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
        assign press[k] = press_q;
    end

    logic [W-1:0]  count_q, count_d, count_prev_q;
    logic          start_q, pending_q;
    logic          eng_busy, eng_done;
    logic [BW-1:0] eng_bcd, bcd_q;

    always_comb begin
        count_d = (press[0] && !press[1]) ? (count_q == MAX_V ? '0 : count_q + 1'b1)
                : (press[1] && !press[0]) ? (count_q == '0 ? MAX_V : count_q - 1'b1)
                : count_q;
    end

    // start fires the cycle after count moves; a change seen while the engine is
    // busy is held in pending_q and replayed once the engine is back in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            count_prev_q <= '0;
            start_q      <= 1'b0;
            pending_q    <= 1'b0;
            bcd_q        <= '0;
        end else begin
            count_q      <= count_d;
            count_prev_q <= count_q;
            start_q      <= count_q != count_prev_q;
            pending_q    <= eng_busy & (pending_q | start_q);
            if (eng_done)
                bcd_q <= eng_bcd;
        end
    end

    bin2bcd_seq #(
        .W        (W),
        .N_DIGITS (N_DIGITS)
    ) u_b2b (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start_q | pending_q),
        .bin   (count_q),
        .busy  (eng_busy),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    logic [SW-1:0]   ref_q;
    logic [IW-1:0]   idx_q;
    logic [6:0]      seg_q, seg_d;
    logic [AN_W-1:0] an_q, an_d;
    logic [BW-1:0]   upper;
    logic            blank;

    // upper holds the current digit and everything more significant in its low bits
    always_comb begin
        upper = bcd_q >> (4 * (N_DIGITS - 1 - int'(idx_q)));
        blank = blank_lz && idx_q != ID_LAST && upper == '0;
        seg_d = blank ? SEG_BLANK : seg_decode(upper[3:0]);
        an_d  = ~(AN_W'(1) << (AN_W - 1 - int'(idx_q)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= '0;
            idx_q <= '0;
            seg_q <= seg_decode(4'd0);
            an_q  <= ~(AN_W'(1) << (AN_W - 1));
        end else begin
            ref_q <= ref_q == SC_LAST ? '0 : ref_q + 1'b1;
            if (ref_q == SC_LAST)
                idx_q <= idx_q == ID_LAST ? '0 : idx_q + 1'b1;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign count = count_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule
